data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, data-memory byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, data-bus width.
REQ-003 Parameter STARVE_LIMIT, default 8, maximum number of cycles a pending debug request waits before it is forced.
REQ-004 Port clk  input  1  clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset; asynchronous, active-high.
REQ-006 Port cpu_rd_en / cpu_wr_en  input  1 each  MEM-stage read/write enables.
REQ-007 Port cpu_addr  input  ADDR_WIDTH; cpu_wdata  input  DATA_WIDTH; cpu_funct3  input  3  MEM-stage access fields.
REQ-008 Port cpu_rdata  output  DATA_WIDTH  load data returned to the MEM/WB path.
REQ-009 Port cpu_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM and bubbles MEM/WB while high.
REQ-010 Port dbg_req, dbg_we  input  1 each; dbg_addr  input  ADDR_WIDTH; dbg_wdata  input  DATA_WIDTH  debug/loader request port (word access, funct3=3'b010).
REQ-011 Port dbg_gnt  output  1; dbg_rvalid  output  1; dbg_rdata  output  DATA_WIDTH  debug grant and read response.
REQ-012 Port mem_rd_en, mem_wr_en  output  1; mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH; mem_funct3  output  3; mem_rdata  input  DATA_WIDTH  DataMemory side.

Function
REQ-013 The FSM SHALL have three states: IDLE (no debug request pending), WAIT (debug pending, CPU owns memory), FORCE (debug owns memory, CPU stalled).
REQ-014 cpu_access is cpu_rd_en | cpu_wr_en; DataMemory reads are combinational and writes occur on the clock edge.
REQ-015 In IDLE or WAIT with dbg_req=1 and cpu_access=0, dbg_gnt SHALL be asserted combinationally in that cycle, and the memory port SHALL be driven by the debug fields.
REQ-016 In all other IDLE/WAIT cycles, the memory port SHALL pass the CPU fields through unchanged, and cpu_stall SHALL be 0.
REQ-017 IDLE to WAIT occurs when dbg_req=1 and cpu_access=1; starve_cnt SHALL load 1.
REQ-018 In WAIT, starve_cnt SHALL increment each cycle the request is not granted; when starve_cnt==STARVE_LIMIT-1 and cpu_access=1, the next state SHALL be FORCE.
REQ-019 In FORCE: cpu_stall=1, dbg_gnt=1 and the memory port is driven by debug for exactly one cycle; the next state SHALL be IDLE and starve_cnt SHALL be 0.
REQ-020 An opportunistic grant in WAIT SHALL return to IDLE and clear starve_cnt.
REQ-021 dbg_req deasserted in WAIT (abandon) SHALL return to IDLE and clear starve_cnt, with no grant issued.
REQ-022 dbg_gnt SHALL be a single-cycle pulse per transfer; the requester holds its fields stable until dbg_gnt and drops dbg_req the cycle after.
REQ-023 For a granted read (dbg_we=0), dbg_rdata SHALL register mem_rdata, and dbg_rvalid SHALL pulse high the cycle after the grant; writes SHALL produce no dbg_rvalid.
REQ-024 cpu_rdata SHALL equal mem_rdata when the CPU owns the port, and 0 otherwise.
REQ-025 Back-to-back debug requests with the CPU idle SHALL be granted on consecutive cycles.
REQ-026 starve_cnt SHALL saturate, never wrap; its width is $clog2(STARVE_LIMIT)+1.
REQ-027 When a debug grant and a CPU access coincide in FORCE, the CPU access SHALL be replayed (held by the stall) and never dropped.

Reset
REQ-028 While rst=1: state=IDLE, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0, dbg_gnt=0, cpu_stall=0, mem_rd_en=0, mem_wr_en=0.
REQ-029 Asserting rst mid-FORCE SHALL cancel the transfer; no memory write SHALL occur in that cycle.
REQ-030 The first grant after reset deasserts SHALL be possible in the first clock cycle.

Structure
REQ-031 The state enum arb_state_t (IDLE, WAIT, FORCE) SHALL live in the shared package alongside the pipeline register typedefs.
REQ-032 The DBG_FUNCT3 word-access constant (3'b010) SHALL live in the shared package.
REQ-033 A single sub-module, starve_counter (saturating, with clear and enable), is natural; all other logic is flat.

Verification
REQ-034 CPU idle, dbg read addr 0x010 (mem=0xDEADBEEF) -> dbg_gnt in the same cycle, dbg_rvalid plus 0xDEADBEEF next cycle, cpu_stall never 1.
REQ-035 CPU continuous loads, dbg write 0x55 to 0x020, STARVE_LIMIT=8 -> FORCE on the 8th cycle, cpu_stall high for exactly one cycle, mem[0x020]=0x55, and the CPU load is completed afterwards.
REQ-036 CPU busy for 3 cycles then idle -> grant on cycle 4, starve_cnt cleared, no stall.
REQ-037 dbg_req dropped after 2 WAIT cycles -> return to IDLE, no dbg_gnt, no memory write.
REQ-038 rst pulsed during FORCE of a write -> memory unchanged, all outputs at reset values, state IDLE.
REQ-039 Four back-to-back debug reads with the CPU idle -> four consecutive grants and four rvalid pulses in order.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, memory-port control
// bundle and the fixed debug access width.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  // Debug/loader accesses are always full 32-bit words.
  localparam logic [2:0] DBG_FUNCT3 = 3'b010;

  typedef struct packed {
    logic       rd_en;
    logic       wr_en;
    logic [2:0] funct3;
  } mem_ctrl_t;

  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear, used to bound debug waiting.
module starve_counter #(
  parameter int LIMIT = 8,
  parameter int W     = $clog2(LIMIT) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = W'(LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != MAX) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one DataMemory port between the CPU MEM stage and a debug/loader
// port; the CPU wins until the debug request has starved long enough.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd_en,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] FORCE_AT = CW'(STARVE_LIMIT - 1);

  arb_state_t    state;
  logic [CW-1:0] starve_cnt;
  logic          cpu_access;
  logic          dbg_win;
  logic          cnt_clr;
  logic          cnt_en;
  mem_ctrl_t     cpu_ctrl;
  mem_ctrl_t     dbg_ctrl;
  mem_ctrl_t     mem_ctrl;

  assign cpu_access = cpu_rd_en | cpu_wr_en;
  assign cpu_ctrl   = '{rd_en: cpu_rd_en, wr_en: cpu_wr_en, funct3: cpu_funct3};
  assign dbg_ctrl   = '{rd_en: ~dbg_we, wr_en: dbg_we, funct3: DBG_FUNCT3};

  // Debug owns the port when forced, or opportunistically when the CPU is quiet.
  always_comb begin
    dbg_win = 1'b0;
    if (!rst) begin
      if (state == FORCE) begin
        dbg_win = 1'b1;
      end else begin
        dbg_win = dbg_req & ~cpu_access;
      end
    end
  end

  assign dbg_gnt   = dbg_win;
  assign cpu_stall = ~rst & (state == FORCE);
  assign cpu_rdata = dbg_win ? '0 : mem_rdata;

  always_comb begin
    mem_ctrl  = cpu_ctrl;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dbg_win) begin
      mem_ctrl  = dbg_ctrl;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
    if (rst) begin
      mem_ctrl.rd_en = 1'b0;
      mem_ctrl.wr_en = 1'b0;
    end
  end

  assign mem_rd_en  = mem_ctrl.rd_en;
  assign mem_wr_en  = mem_ctrl.wr_en;
  assign mem_funct3 = mem_ctrl.funct3;

  // The counter is zero in IDLE, so enabling it on IDLE->WAIT loads 1.
  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      IDLE, WAIT: begin
        cnt_en  = dbg_req & cpu_access;
        cnt_clr = ~cnt_en;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (CW)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (starve_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_win & ~dbg_we;
      if (dbg_win && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
      case (state)
        IDLE: begin
          if (dbg_req && cpu_access) state <= WAIT;
        end
        WAIT: begin
          if (!dbg_req || !cpu_access) begin
            state <= IDLE;
          end else if (starve_cnt == FORCE_AT) begin
            state <= FORCE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural DataMemory and a
// scoreboard of expected debug read data.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_en, cpu_wr_en;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int rv_count = 0;
  int wr_count;
  logic [31:0] exp_q[$];

  logic        mem_clr;
  logic [31:0] wr_data [512];
  logic [511:0] wr_valid;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_rd_en  (cpu_rd_en),
    .cpu_wr_en  (cpu_wr_en),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_funct3 (cpu_funct3),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] dflt(input logic [8:0] a);
    if (a == 9'h010) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  // DataMemory model: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (mem_clr) begin
      wr_valid <= '0;
      wr_count <= 0;
    end else if (mem_wr_en) begin
      wr_data[mem_addr]  <= mem_wdata;
      wr_valid[mem_addr] <= 1'b1;
      wr_count           <= wr_count + 1;
    end
  end

  assign mem_rdata = wr_valid[mem_addr] ? wr_data[mem_addr] : dflt(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic [31:0] e;
    if (dbg_rvalid === 1'b1) begin
      rv_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL rvalid_unexpected observed=1 expected=0");
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dbg_rdata", dbg_rdata, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
    mon();
  endtask

  task automatic cpu_set(input logic rd, input logic [8:0] a);
    cpu_rd_en = rd;
    cpu_wr_en = 1'b0;
    cpu_addr  = a;
  endtask

  task automatic dbg_set(input logic req, input logic we, input logic [8:0] a, input logic [31:0] d);
    dbg_req   = req;
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = d;
  endtask

  initial begin
    logic [8:0]  rd_addrs [4];
    logic [31:0] rd_exp [4];
    int          wc;

    rst = 1'b1;
    mem_clr = 1'b1;
    cpu_set(1'b0, 9'h000);
    cpu_wdata  = '0;
    cpu_funct3 = 3'b010;
    dbg_set(1'b1, 1'b0, 9'h010, 32'h0);

    // Reset holds every control output low even with a request pending.
    repeat (2) tick();
    settle();
    chk("rst_gnt", dbg_gnt, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_rd", mem_rd_en, 0);
    chk("rst_mem_wr", mem_wr_en, 0);
    chk("rst_rvalid", dbg_rvalid, 0);
    chk("rst_rdata", dbg_rdata, 0);

    // First cycle after reset: opportunistic debug read of 0x010.
    tick();
    rst = 1'b0;
    mem_clr = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    settle();
    chk("first_gnt", dbg_gnt, 1);
    chk("first_mem_rd", mem_rd_en, 1);
    chk("first_mem_addr", mem_addr, 32'h010);
    chk("first_funct3", mem_funct3, 32'h2);
    chk("first_stall", cpu_stall, 0);
    chk("first_cpu_rdata", cpu_rdata, 0);
    tick();
    dbg_set(1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    chk("first_gnt_pulse", dbg_gnt, 0);
    chk("first_stall_after", cpu_stall, 0);

    // CPU store passes through untouched.
    tick();
    cpu_wr_en  = 1'b1;
    cpu_addr   = 9'h080;
    cpu_wdata  = 32'h0000_1234;
    cpu_funct3 = 3'b001;
    settle();
    chk("cpu_wr_pass", mem_wr_en, 1);
    chk("cpu_wdata_pass", mem_wdata, 32'h1234);
    chk("cpu_funct3_pass", mem_funct3, 32'h1);
    chk("cpu_addr_pass", mem_addr, 32'h080);
    chk("cpu_wr_gnt", dbg_gnt, 0);
    tick();
    cpu_set(1'b0, 9'h000);
    cpu_funct3 = 3'b010;

    // CPU busy three cycles, then idle: grant on the fourth.
    for (int i = 0; i < 3; i++) begin
      cpu_set(1'b1, 9'h050);
      dbg_set(1'b1, 1'b0, 9'h040, 32'h0);
      settle();
      chk("busy_gnt", dbg_gnt, 0);
      chk("busy_stall", cpu_stall, 0);
      chk("busy_cpu_rdata", cpu_rdata, dflt(9'h050));
      tick();
    end
    cpu_set(1'b0, 9'h000);
    exp_q.push_back(dflt(9'h040));
    settle();
    chk("late_gnt", dbg_gnt, 1);
    chk("late_stall", cpu_stall, 0);
    chk("late_addr", mem_addr, 32'h040);
    tick();
    dbg_set(1'b0, 1'b0, 9'h000, 32'h0);
    settle();

    // Abandoned write after two WAIT cycles: no grant, no write.
    wc = wr_count;
    for (int i = 0; i < 3; i++) begin
      tick();
      cpu_set(1'b1, 9'h050);
      dbg_set(1'b1, 1'b1, 9'h060, 32'h77);
      settle();
      chk("abandon_gnt", dbg_gnt, 0);
    end
    tick();
    dbg_set(1'b0, 1'b1, 9'h060, 32'h77);
    settle();
    chk("abandon_gnt_drop", dbg_gnt, 0);
    chk("abandon_stall", cpu_stall, 0);
    tick();
    cpu_set(1'b0, 9'h000);
    settle();
    chk("abandon_no_write", wr_count, wc);

    // Continuous CPU loads: debug write forced after eight starved cycles.
    for (int i = 0; i < 8; i++) begin
      tick();
      cpu_set(1'b1, 9'h030);
      dbg_set(1'b1, 1'b1, 9'h020, 32'h55);
      settle();
      chk("starve_gnt", dbg_gnt, 0);
      chk("starve_stall", cpu_stall, 0);
      chk("starve_cpu_rdata", cpu_rdata, dflt(9'h030));
    end
    tick();
    settle();
    chk("force_stall", cpu_stall, 1);
    chk("force_gnt", dbg_gnt, 1);
    chk("force_mem_wr", mem_wr_en, 1);
    chk("force_mem_rd", mem_rd_en, 0);
    chk("force_addr", mem_addr, 32'h020);
    chk("force_wdata", mem_wdata, 32'h55);
    chk("force_cpu_rdata", cpu_rdata, 0);
    tick();
    dbg_set(1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    chk("replay_stall", cpu_stall, 0);
    chk("replay_gnt", dbg_gnt, 0);
    chk("replay_mem_rd", mem_rd_en, 1);
    chk("replay_addr", mem_addr, 32'h030);
    chk("replay_cpu_rdata", cpu_rdata, dflt(9'h030));
    tick();
    cpu_set(1'b0, 9'h000);

    // Reset pulsed during the FORCE cycle of a write cancels it.
    for (int i = 0; i < 9; i++) begin
      cpu_set(1'b1, 9'h030);
      dbg_set(1'b1, 1'b1, 9'h070, 32'hBAD);
      if (i < 8) tick();
    end
    settle();
    chk("pre_rst_force", cpu_stall, 1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", cpu_stall, 0);
    chk("midrst_gnt", dbg_gnt, 0);
    chk("midrst_mem_wr", mem_wr_en, 0);
    chk("midrst_mem_rd", mem_rd_en, 0);
    chk("midrst_rvalid", dbg_rvalid, 0);
    chk("midrst_rdata", dbg_rdata, 0);
    tick();
    rst = 1'b0;
    cpu_set(1'b0, 9'h000);
    dbg_set(1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    chk("postrst_gnt", dbg_gnt, 0);

    // Four back-to-back debug reads, also confirming memory contents.
    rd_addrs[0] = 9'h010; rd_exp[0] = 32'hDEADBEEF;
    rd_addrs[1] = 9'h020; rd_exp[1] = 32'h0000_0055;
    rd_addrs[2] = 9'h060; rd_exp[2] = dflt(9'h060);
    rd_addrs[3] = 9'h070; rd_exp[3] = dflt(9'h070);
    for (int i = 0; i < 4; i++) begin
      tick();
      dbg_set(1'b1, 1'b0, rd_addrs[i], 32'h0);
      exp_q.push_back(rd_exp[i]);
      settle();
      chk("b2b_gnt", dbg_gnt, 1);
      chk("b2b_addr", mem_addr, {23'd0, rd_addrs[i]});
    end
    tick();
    dbg_set(1'b0, 1'b0, 9'h000, 32'h0);
    settle();
    chk("b2b_gnt_end", dbg_gnt, 0);
    tick();
    settle();

    chk("rvalid_total", rv_count, 6);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
